// File: rtl/efpga_ccff_chain_loader_pkg.sv
// efpga_ccff_pkg: FSM state type and CRC-16-CCITT constants shared by the CCFF chain loader.
package efpga_ccff_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FIN} ccff_state_e;
    localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
    localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/efpga_ccff_chain_loader_if.sv
// efpga_ccff_chain_loader_if: valid/ready configuration word stream into the loader.
interface efpga_ccff_chain_loader_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    modport master(output s_data, s_valid, input s_ready);
    modport slave(input s_data, s_valid, output s_ready);
endinterface

// File: rtl/efpga_ccff_chain_loader_crc.sv
// efpga_ccff_tail_crc16: serial CRC-16-CCITT over the chain tail; built only with EFPGA_CCFF_TAIL_CRC_EN.
`ifdef EFPGA_CCFF_TAIL_CRC_EN
module efpga_ccff_tail_crc16
    import efpga_ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) crc_q <= CCFF_CRC_INIT;
        else if (init_i) crc_q <= CCFF_CRC_INIT;
        else if (en_i) crc_q <= {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_i) ? CCFF_CRC_POLY : 16'h0000);
    assign crc_o = crc_q;
endmodule
`endif

// File: rtl/efpga_ccff_chain_loader.sv
// efpga_ccff_chain_loader: serializes stream words MSB-first into a CCFF chain for a programmed bit count.
// Optional tail readback CRC is built when EFPGA_CCFF_TAIL_CRC_EN is defined.
module efpga_ccff_chain_loader
    import efpga_ccff_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       prog_clk,
    input  logic                       pReset,
    input  logic                       cfg_start,
    input  logic [CNT_W-1:0]           cfg_len,
    efpga_ccff_chain_loader_if.slave   s,
    output logic                       ccff_head,
    output logic                       ccff_shift_en,
    input  logic                       ccff_tail,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                tail_crc
);
    localparam int BW = $clog2(DATA_W + 1);
    ccff_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              ready_q, head_q, en_q, busy_q, done_q, done_d, take;
    assign take = s.s_valid && ready_q;
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (cfg_start) begin
                rem_d   = cfg_len;
                state_d = cfg_len == '0 ? FIN : FETCH;
            end
            FETCH: if (take) begin
                shreg_d  = s.s_data;
                bitcnt_d = BW'(DATA_W);
                state_d  = SHIFT;
            end
            SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q - BW'(1);
                rem_d    = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else if (bitcnt_q == BW'(1)) begin
                    if (take) begin
                        shreg_d  = s.s_data;
                        bitcnt_d = BW'(DATA_W);
                    end else state_d = FETCH;
                end
            end
            FIN: begin
                // a zero-length load arrives here without a shift, so it spends one cycle before pulsing done
                done_d  = !done_q;
                state_d = done_q ? IDLE : FIN;
            end
        endcase
    end
    always_ff @(posedge prog_clk or posedge pReset)
        if (pReset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            rem_q    <= '0;
            ready_q  <= 1'b0;
            head_q   <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            rem_q    <= rem_d;
            ready_q  <= state_d == FETCH || (state_d == SHIFT && bitcnt_d == BW'(1) && rem_d > CNT_W'(1));
            head_q   <= state_d == SHIFT && shreg_d[DATA_W-1];
            en_q     <= state_d == SHIFT;
            busy_q   <= state_d == FETCH || state_d == SHIFT || (state_d == FIN && !done_d);
            done_q   <= done_d;
        end
    assign s.s_ready     = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = en_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef EFPGA_CCFF_TAIL_CRC_EN
    efpga_ccff_tail_crc16 u_crc (
        .clk   (prog_clk),
        .rst   (pReset),
        .init_i(cfg_start && state_q == IDLE),
        .en_i  (en_q),
        .bit_i (ccff_tail),
        .crc_o (tail_crc)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign tail_crc    = '0;
`endif
endmodule

// File: tb/tb_efpga_ccff_chain_loader.sv
// tb_efpga_ccff_chain_loader: directed loads checked against a bit-stream model of the chain loader.
module tb_efpga_ccff_chain_loader;
    logic        clk = 1'b0, rst = 1'b1, cfg_start = 1'b0, tail = 1'b0, tail_rand = 1'b0;
    logic [15:0] cfg_len = '0;
    logic        head, en, busy, done;
    logic [15:0] tail_crc;
    efpga_ccff_chain_loader_if #(.DATA_W(8)) sif ();
    efpga_ccff_chain_loader #(.DATA_W(8), .CNT_W(16)) dut (
        .prog_clk(clk), .pReset(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .s(sif),
        .ccff_head(head), .ccff_shift_en(en), .ccff_tail(tail), .busy(busy), .done(done), .tail_crc(tail_crc)
    );
    always #5 clk = ~clk;
`ifdef EFPGA_CCFF_TAIL_CRC_EN
    localparam logic [15:0] CRC_RST = 16'hFFFF;
    localparam bit          CRC_ON  = 1'b1;
`else
    localparam logic [15:0] CRC_RST = 16'h0000;
    localparam bit          CRC_ON  = 1'b0;
`endif
    int n_cmp = 0, n_bad = 0;
    logic [7:0]  stim_w [4];
    int          stim_gap = 0;
    int          cyc = 0, start_cyc = 0, dcyc_m = 0, len_m = 0, shifts_m = 0, words_m = 0, bubbles_m = 0;
    logic        act_m = 1'b0, done_seen = 1'b0;
    logic [15:0] crc_m = 16'hFFFF, cap_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input int i);
        logic [7:0] w;
        w = stim_w[i / 8];
        return w[7 - i % 8];
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        #1;
        if (tail_rand) tail = 1'($urandom_range(1, 0));
    end

    // compare process: the expected chain stream is the concatenated words, MSB first, cut to cfg_len bits
    always @(negedge clk) begin
        if (rst) act_m = 1'b0;
        else begin
            cyc++;
            if (!act_m) begin
                chk("idle_ready", sif.s_ready, 0);
                chk("idle_shift", en, 0);
                if (cfg_start) begin
                    act_m = 1'b1; start_cyc = cyc; len_m = int'(cfg_len);
                    shifts_m = 0; words_m = 0; bubbles_m = 0; done_seen = 1'b0; crc_m = 16'hFFFF; cap_m = '0;
                end
            end else begin
                if (sif.s_valid && sif.s_ready) words_m++;
                if (en) begin
                    if (shifts_m < len_m) chk("head", head, exp_bit(shifts_m));
                    else chk("excess_shift", shifts_m, len_m);
                    crc_m = crc_step(crc_m, tail);
                    cap_m = {cap_m[14:0], head};
                    shifts_m++;
                end else if (shifts_m > 0 && shifts_m < len_m) bubbles_m++;
                if (done) begin
                    dcyc_m = cyc - start_cyc;
                    chk("done_busy", busy, 0);
                    chk("done_shifts", shifts_m, len_m);
                    chk("done_words", words_m, (len_m + 7) / 8);
                    chk("done_bubbles", bubbles_m, stim_gap);
                    if (stim_gap == 0) chk("done_cycle", dcyc_m, len_m + 2);
                    chk("done_crc", tail_crc, CRC_ON ? crc_m : 16'h0000);
                    act_m = 1'b0;
                    done_seen = 1'b1;
                end else chk("busy", busy, 1);
            end
        end
    end

    task automatic run_load(input int len, input int gap, input int abort_at);
        int   wi = 0, guard = 0;
        logic hs;
        stim_gap = gap;
        sif.s_data = stim_w[0];
        sif.s_valid = 1'b1;
        cfg_len = 16'(len);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_len = 16'hFFFF;
        while (!done_seen && guard < 200) begin
            guard++;
            @(negedge clk);
            hs = sif.s_valid && sif.s_ready;
            @(posedge clk); #1;
            cfg_start = guard == 3 && len >= 8;
            if (abort_at > 0 && shifts_m >= abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_ready", sif.s_ready, 0);
                chk("abort_head", head, 0);
                chk("abort_shift", en, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_crc", tail_crc, CRC_RST);
                cfg_start = 1'b0;
                sif.s_valid = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (hs) begin
                wi++;
                sif.s_data = stim_w[wi % 4];
                if (wi == 1 && gap > 0) begin
                    sif.s_valid = 1'b0;
                    for (int k = 0; k < 50 && !sif.s_ready; k++) begin
                        @(posedge clk); #1;
                    end
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    sif.s_valid = 1'b1;
                end
            end
        end
        cfg_start = 1'b0;
        chk("done_seen", done_seen, 1);
        sif.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", sif.s_ready, 0);
        chk("rst_head", head, 0);
        chk("rst_shift", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crc", tail_crc, CRC_RST);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        stim_w = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_load(8, 0, 0);
        chk("a5_bits", cap_m[7:0], 8'hA5);
        chk("a5_cycles", dcyc_m, 10);
        stim_w = '{8'h3C, 8'hF0, 8'hFF, 8'hFF};
        run_load(12, 0, 0);
        chk("two_word_bits", cap_m[11:0], 12'h3CF);
        chk("two_word_count", words_m, 2);
        tail_rand = 1'b1;
        stim_w = '{8'h5A, 8'hC3, 8'h81, 8'h7E};
        run_load(16, 3, 0);
        chk("gap_bits", cap_m, 16'h5AC3);
        chk("gap_bubbles", bubbles_m, 3);
        tail_rand = 1'b0;
        run_load(0, 0, 0);
        chk("zero_cycle", dcyc_m, 2);
        chk("zero_words", words_m, 0);
        stim_w = '{8'hFF, 8'h0F, 8'h00, 8'h00};
        run_load(16, 0, 5);
        stim_w = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_load(8, 0, 0);
        chk("post_reset_bits", cap_m[7:0], 8'hA5);
        tail = 1'b1;
        stim_w = '{8'h12, 8'h34, 8'h00, 8'h00};
        run_load(16, 0, 0);
        chk("crc_ones", tail_crc, 16'h0000);
        tail = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
